// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, register-zero constant,
// the ID/EX bundle held by the operand stage and its bubble value.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;

  localparam logic [5:0] ALU_BUBBLE = ALU_ADD;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            sgn;
    logic [5:0]      alufunc;
    logic [4:0]      rs_addr;
    logic [4:0]      rt_addr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic [15:0]     imm;
    logic [4:0]      shamt;
    logic            srca_shamt;
    logic            srcb_imm;
    logic            extop;
    logic            lui;
  } id_ex_t;

  function automatic id_ex_t bubble();
    id_ex_t b;
    b = '0;
    b.alufunc = ALU_BUBBLE;
    return b;
  endfunction

  function automatic logic [XLEN-1:0] ext_imm(
    input logic [15:0] imm,
    input logic        extop
  );
    if (extop)
      return {{16{imm[15]}}, imm};
    return {16'b0, imm};
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// ID/EX operand stage bus: ID-side inputs, forwarding sources,
// ALU operands/controls and EX control outputs.
interface alu_operand_stage_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] id_rs_data;
  logic [WIDTH-1:0] id_rt_data;
  logic [4:0]       id_rs_addr;
  logic [4:0]       id_rt_addr;
  logic [4:0]       id_rd_addr;
  logic [15:0]      id_imm;
  logic [4:0]       id_shamt;
  logic [5:0]       id_alufunc;
  logic             id_signed;
  logic             id_srca_shamt;
  logic             id_srcb_imm;
  logic             id_extop;
  logic             id_lui;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_memwrite;
  logic             exmem_regwrite;
  logic [4:0]       exmem_rd;
  logic [WIDTH-1:0] exmem_result;
  logic             memwb_regwrite;
  logic [4:0]       memwb_rd;
  logic [WIDTH-1:0] memwb_result;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Signed;
  logic [5:0]       ALUFunc;
  logic             ex_valid;
  logic             ex_regwrite;
  logic             ex_memread;
  logic             ex_memwrite;
  logic [4:0]       ex_rd;
  logic [WIDTH-1:0] ex_store_data;
  logic             load_use_stall;

  modport master (
    output in_valid, stall, flush,
    output id_rs_data, id_rt_data,
    output id_rs_addr, id_rt_addr, id_rd_addr,
    output id_imm, id_shamt, id_alufunc,
    output id_signed, id_srca_shamt,
    output id_srcb_imm, id_extop, id_lui,
    output id_regwrite, id_memread, id_memwrite,
    output exmem_regwrite, exmem_rd, exmem_result,
    output memwb_regwrite, memwb_rd, memwb_result,
    input  A, B, Signed, ALUFunc,
    input  ex_valid, ex_regwrite,
    input  ex_memread, ex_memwrite,
    input  ex_rd, ex_store_data,
    input  load_use_stall
  );

  modport slave (
    input  in_valid, stall, flush,
    input  id_rs_data, id_rt_data,
    input  id_rs_addr, id_rt_addr, id_rd_addr,
    input  id_imm, id_shamt, id_alufunc,
    input  id_signed, id_srca_shamt,
    input  id_srcb_imm, id_extop, id_lui,
    input  id_regwrite, id_memread, id_memwrite,
    input  exmem_regwrite, exmem_rd, exmem_result,
    input  memwb_regwrite, memwb_rd, memwb_result,
    output A, B, Signed, ALUFunc,
    output ex_valid, ex_regwrite,
    output ex_memread, ex_memwrite,
    output ex_rd, ex_store_data,
    output load_use_stall
  );

endinterface

// File: rtl/fwd_mux.sv
// One forwarding selector: EX/MEM beats MEM/WB beats register value.
// Ports: source addr/value, both forwarding sources, selected value y.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [4:0]   addr,
  input  logic [W-1:0] regval,
  input  logic         exmem_regwrite,
  input  logic [4:0]   exmem_rd,
  input  logic [W-1:0] exmem_result,
  input  logic         memwb_regwrite,
  input  logic [4:0]   memwb_rd,
  input  logic [W-1:0] memwb_result,
  output logic [W-1:0] y
);

  logic nz;
  logic ex_hit;
  logic wb_hit;

  assign nz = (addr != REG_ZERO);
  assign ex_hit = nz & exmem_regwrite
                & (exmem_rd == addr);
  assign wb_hit = nz & memwb_regwrite
                & (memwb_rd == addr);

  always_comb begin
    y = regval;
    unique case (1'b1)
      ex_hit:            y = exmem_result;
      wb_hit && !ex_hit: y = memwb_result;
      default:           y = regval;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage feeding the ALU: operand regs, forwarding, load-use
// bubbles, hold/flush. Ports: clk, reset, bus (slave side).
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  alu_operand_stage_if.slave bus
);

  id_ex_t           q;
  id_ex_t           d;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             lus;

  fwd_mux #(.W(WIDTH)) u_fwd_rs (
    .addr           (q.rs_addr),
    .regval         (q.rs),
    .exmem_regwrite (bus.exmem_regwrite),
    .exmem_rd       (bus.exmem_rd),
    .exmem_result   (bus.exmem_result),
    .memwb_regwrite (bus.memwb_regwrite),
    .memwb_rd       (bus.memwb_rd),
    .memwb_result   (bus.memwb_result),
    .y              (fwd_rs)
  );

  fwd_mux #(.W(WIDTH)) u_fwd_rt (
    .addr           (q.rt_addr),
    .regval         (q.rt),
    .exmem_regwrite (bus.exmem_regwrite),
    .exmem_rd       (bus.exmem_rd),
    .exmem_result   (bus.exmem_result),
    .memwb_regwrite (bus.memwb_regwrite),
    .memwb_rd       (bus.memwb_rd),
    .memwb_result   (bus.memwb_result),
    .y              (fwd_rt)
  );

  // Both sources compared even if unused: cheap and conservative.
  assign lus = q.valid & q.memread
             & (q.rd != REG_ZERO)
             & bus.in_valid
             & ((q.rd == bus.id_rs_addr)
              | (q.rd == bus.id_rt_addr));

  always_comb begin
    d = bubble();
    if (bus.in_valid) begin
      d.valid      = 1'b1;
      d.regwrite   = bus.id_regwrite;
      d.memread    = bus.id_memread;
      d.memwrite   = bus.id_memwrite;
      d.sgn        = bus.id_signed;
      d.alufunc    = bus.id_alufunc;
      d.rs_addr    = bus.id_rs_addr;
      d.rt_addr    = bus.id_rt_addr;
      d.rd         = bus.id_rd_addr;
      d.rs         = bus.id_rs_data;
      d.rt         = bus.id_rt_data;
      d.imm        = bus.id_imm;
      d.shamt      = bus.id_shamt;
      d.srca_shamt = bus.id_srca_shamt;
      d.srcb_imm   = bus.id_srcb_imm;
      d.extop      = bus.id_extop;
      d.lui        = bus.id_lui;
    end
  end

  always_comb begin
    opa = fwd_rs;
    if (q.srca_shamt)
      opa = {{(WIDTH-5){1'b0}}, q.shamt};
  end

  always_comb begin
    opb = fwd_rt;
    unique case (1'b1)
      q.lui:
        opb = {q.imm, 16'b0};
      q.srcb_imm && !q.lui:
        opb = ext_imm(q.imm, q.extop);
      default:
        opb = fwd_rt;
    endcase
  end

  // On hold, latch forwarded sources so they survive producer retire.
  always_ff @(posedge clk) begin
    if (reset)
      q <= bubble();
    else if (bus.flush)
      q <= bubble();
    else if (bus.stall) begin
      q.rs <= fwd_rs;
      q.rt <= fwd_rt;
    end
    else if (lus)
      q <= bubble();
    else
      q <= d;
  end

  assign bus.A              = opa;
  assign bus.B              = opb;
  assign bus.Signed         = q.sgn;
  assign bus.ALUFunc        = q.alufunc;
  assign bus.ex_valid       = q.valid;
  assign bus.ex_regwrite    = q.regwrite;
  assign bus.ex_memread     = q.memread;
  assign bus.ex_memwrite    = q.memwrite;
  assign bus.ex_rd          = q.rd;
  assign bus.ex_store_data  = fwd_rt;
  assign bus.load_use_stall = lus;

endmodule
